// File: rtl/ipsxe_floating_point_pkg.sv
// rtl/ipsxe_floating_point_pkg.sv - shared widths, special-value patterns and operand classes
package ipsxe_floating_point_pkg;

  localparam int DEF_EXPONENT_SIZE = 11;
  localparam int DEF_MANTISSA_SIZE = 52;
  localparam int DEF_GUARD_BITS    = 3;

  localparam int W_MANT_IN = DEF_MANTISSA_SIZE + DEF_GUARD_BITS + 2;
  localparam int W_RESULT  = DEF_EXPONENT_SIZE + DEF_MANTISSA_SIZE + 1;

  localparam logic [W_RESULT-1:0] QNAN_PATTERN =
    {1'b0, {DEF_EXPONENT_SIZE{1'b1}}, 1'b1, {(DEF_MANTISSA_SIZE-1){1'b0}}};
  localparam logic [W_RESULT-1:0] INF_PATTERN =
    {1'b0, {DEF_EXPONENT_SIZE{1'b1}}, {DEF_MANTISSA_SIZE{1'b0}}};
  localparam logic [W_RESULT-1:0] ZERO_PATTERN = '0;

  typedef enum logic [1:0] {
    CLS_FINITE = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } op_class_e;

  // NaN wins over everything so a malformed multi-hot class still yields a NaN result
  function automatic op_class_e classify(input logic is_zero, input logic is_inf,
                                         input logic is_nan);
    if (is_nan)       return CLS_NAN;
    else if (is_zero) return CLS_ZERO;
    else if (is_inf)  return CLS_INF;
    else              return CLS_FINITE;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_round_rne_v1_0.sv
// rtl/ipsxe_floating_point_round_rne_v1_0.sv - combinational round-to-nearest-even incrementer
module ipsxe_floating_point_round_rne_v1_0 #(
  parameter int MANTISSA_SIZE = 52,
  parameter int GUARD_BITS    = 3
) (
  input  logic [MANTISSA_SIZE+GUARD_BITS+1:0] value,
  output logic [MANTISSA_SIZE+1:0]            rounded
);

  logic lsb;
  logic rnd;
  logic sticky;
  logic incr;

  assign lsb    = value[GUARD_BITS];
  assign rnd    = value[GUARD_BITS-1];
  assign sticky = |value[GUARD_BITS-2:0];
  // Round up above half, or exactly at half when the kept LSB is odd
  assign incr   = rnd & (sticky | lsb);

  // Input never exceeds 2.0, and 2.0 has clear guard bits, so the add cannot overflow
  assign rounded = value[MANTISSA_SIZE+GUARD_BITS+1:GUARD_BITS]
                 + {{(MANTISSA_SIZE+1){1'b0}}, incr};

endmodule

// File: rtl/ipsxe_floating_point_invsqrt_pack_v1_0.sv
// rtl/ipsxe_floating_point_invsqrt_pack_v1_0.sv - invsqrt round, normalise, special override and pack
module ipsxe_floating_point_invsqrt_pack_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int EXPONENT_SIZE = DEF_EXPONENT_SIZE,
  parameter int MANTISSA_SIZE = DEF_MANTISSA_SIZE,
  parameter int GUARD_BITS    = DEF_GUARD_BITS
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [EXPONENT_SIZE-1:0]               i_exp_invsqrt_minus1,
  input  logic [MANTISSA_SIZE+GUARD_BITS+1:0]    i_mant,
  input  logic                                   i_sign,
  input  logic                                   i_is_zero,
  input  logic                                   i_is_inf,
  input  logic                                   i_is_nan,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   o_result,
  output logic                                   o_invalid,
  output logic                                   o_divide_by_zero
);

  localparam int WRND = MANTISSA_SIZE + 2;
  localparam int WRES = EXPONENT_SIZE + MANTISSA_SIZE + 1;

  localparam logic [EXPONENT_SIZE-1:0] EXP_ONES  = '1;
  localparam logic [EXPONENT_SIZE-1:0] EXP_ONE   = {{(EXPONENT_SIZE-1){1'b0}}, 1'b1};
  localparam logic [MANTISSA_SIZE-1:0] FRAC_ZERO = '0;
  localparam logic [WRES-1:0]          QNAN      =
    {1'b0, EXP_ONES, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};

  logic v1;
  logic v2;
  logic ready1;
  logic ready2;

  logic [WRND-1:0]          rnd_value;
  logic [WRND-1:0]          s1_rounded;
  logic [EXPONENT_SIZE-1:0] s1_exp;
  logic                     s1_sign;
  op_class_e                s1_class;

  logic                     carry;
  logic [EXPONENT_SIZE-1:0] exp_out;
  logic [MANTISSA_SIZE-1:0] frac;
  logic [WRES-1:0]          result_d;
  logic                     invalid_d;
  logic                     dbz_d;
  logic                     unused_hidden_bit;

  // A stage accepts new data when empty or when its contents leave this cycle
  assign ready2  = ~v2 | i_ready;
  assign ready1  = ~v1 | ready2;
  assign o_ready = ready1;
  assign o_valid = v2;

  ipsxe_floating_point_round_rne_v1_0 #(
    .MANTISSA_SIZE (MANTISSA_SIZE),
    .GUARD_BITS    (GUARD_BITS)
  ) u_round (
    .value   (i_mant),
    .rounded (rnd_value)
  );

  // Stage 1: capture the rounded significand with exponent, sign and class
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1         <= 1'b0;
      s1_rounded <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_class   <= CLS_FINITE;
    end else if (ready1) begin
      v1 <= i_valid;
      if (i_valid) begin
        s1_rounded <= rnd_value;
        s1_exp     <= i_exp_invsqrt_minus1;
        s1_sign    <= i_sign;
        s1_class   <= classify(i_is_zero, i_is_inf, i_is_nan);
      end
    end
  end

  // A rounded value of exactly 2.0 renormalises to 1.0 with the exponent bumped
  assign carry             = s1_rounded[MANTISSA_SIZE+1];
  assign exp_out           = carry ? (s1_exp + EXP_ONE) : s1_exp;
  assign frac              = carry ? FRAC_ZERO : s1_rounded[MANTISSA_SIZE-1:0];
  assign unused_hidden_bit = s1_rounded[MANTISSA_SIZE];

  // Special-value override in priority order: NaN, zero, infinity, sign check
  always_comb begin
    result_d  = '0;
    invalid_d = 1'b0;
    dbz_d     = 1'b0;
    case (s1_class)
      CLS_NAN: begin
        result_d = QNAN;
      end
      CLS_ZERO: begin
        result_d = {s1_sign, EXP_ONES, FRAC_ZERO};
        dbz_d    = 1'b1;
      end
      CLS_INF: begin
        if (s1_sign) begin
          result_d  = QNAN;
          invalid_d = 1'b1;
        end
      end
      default: begin
        if (s1_sign) begin
          result_d  = QNAN;
          invalid_d = 1'b1;
        end else begin
          result_d = {1'b0, exp_out, frac};
        end
      end
    endcase
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2               <= 1'b0;
      o_result         <= '0;
      o_invalid        <= 1'b0;
      o_divide_by_zero <= 1'b0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        o_result         <= result_d;
        o_invalid        <= invalid_d;
        o_divide_by_zero <= dbz_d;
      end
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_invsqrt_pack_v1_0.sv
// tb/tb_ipsxe_floating_point_invsqrt_pack_v1_0.sv - self-checking bench for the invsqrt pack stage
module tb_ipsxe_floating_point_invsqrt_pack_v1_0;
  import ipsxe_floating_point_pkg::*;

  localparam int E  = DEF_EXPONENT_SIZE;
  localparam int M  = DEF_MANTISSA_SIZE;
  localparam int G  = DEF_GUARD_BITS;
  localparam int WM = W_MANT_IN;
  localparam int WR = W_RESULT;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [E-1:0]  i_exp_invsqrt_minus1;
  logic [WM-1:0] i_mant;
  logic          i_sign;
  logic          i_is_zero;
  logic          i_is_inf;
  logic          i_is_nan;
  logic          o_valid;
  logic          i_ready;
  logic [WR-1:0] o_result;
  logic          o_invalid;
  logic          o_divide_by_zero;

  ipsxe_floating_point_invsqrt_pack_v1_0 dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_valid              (i_valid),
    .o_ready              (o_ready),
    .i_exp_invsqrt_minus1 (i_exp_invsqrt_minus1),
    .i_mant               (i_mant),
    .i_sign               (i_sign),
    .i_is_zero            (i_is_zero),
    .i_is_inf             (i_is_inf),
    .i_is_nan             (i_is_nan),
    .o_valid              (o_valid),
    .i_ready              (i_ready),
    .o_result             (o_result),
    .o_invalid            (o_invalid),
    .o_divide_by_zero     (o_divide_by_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [WR-1:0] result;
    logic          inv;
    logic          dbz;
    string         name;
  } exp_t;

  typedef struct {
    logic [E-1:0]  e;
    logic [WM-1:0] m;
    logic          s;
    logic          z;
    logic          f;
    logic          n;
    logic [WR-1:0] result;
    logic          inv;
    logic          dbz;
    string         name;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic stall_prev = 1'b0;
  logic [WR-1:0] held;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: real-valued RNE on the significand, then IEEE special rules
  function automatic exp_t model(input vec_t v);
    exp_t r;
    longint unsigned mv, q, rem, frac;
    r.inv = 1'b0;
    r.dbz = 1'b0;
    r.name = v.name;
    if (v.n) r.result = QNAN_PATTERN;
    else if (v.z) begin
      r.result = INF_PATTERN | ({64'd1} << (WR - 1)) & {64{v.s}};
      r.dbz = 1'b1;
    end else if (v.f && !v.s) r.result = ZERO_PATTERN;
    else if (v.s) begin
      r.result = QNAN_PATTERN;
      r.inv = 1'b1;
    end else begin
      mv  = 64'(v.m);
      q   = mv / 8;
      rem = mv % 8;
      if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
      if (q == (64'd1 << (M + 1))) r.result = {1'b0, v.e + 11'd1, 52'd0};
      else begin
        frac = q - (64'd1 << M);
        r.result = {1'b0, v.e, frac[M-1:0]};
      end
    end
    return r;
  endfunction

  // Output monitor: scoreboard order, stall stability, no spurious results
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (stall_prev) begin
        check("stall_valid_held", 64'(o_valid), 64'd1);
        check("stall_result_stable", o_result, held);
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) check("unexpected_output", 64'(o_valid), 64'd0);
        else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_result"}, o_result, mon_e.result);
          check({mon_e.name, "_invalid"}, 64'(o_invalid), 64'(mon_e.inv));
          check({mon_e.name, "_dbz"}, 64'(o_divide_by_zero), 64'(mon_e.dbz));
        end
      end
      stall_prev = o_valid && !i_ready;
      held = o_result;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Random downstream backpressure during the random phase
  always @(posedge i_clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input vec_t v, input exp_t x);
    int waited = 0;
    i_valid = 1'b1;
    i_exp_invsqrt_minus1 = v.e;
    i_mant = v.m;
    i_sign = v.s;
    i_is_zero = v.z;
    i_is_inf = v.f;
    i_is_nan = v.n;
    @(negedge i_clk);
    while (!o_ready && waited < 100) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) check("send_timeout", 64'(o_ready), 64'd1);
    else sb.push_back(x);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge i_clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [E-1:0] e, input logic [WM-1:0] m,
                              input logic s, input logic z, input logic f, input logic n,
                              input logic [WR-1:0] res, input logic inv, input logic dbz);
    vec_t v;
    v.name = name; v.e = e; v.m = m; v.s = s; v.z = z; v.f = f; v.n = n;
    v.result = res; v.inv = inv; v.dbz = dbz;
    return v;
  endfunction

  function automatic vec_t rand_vec(input string name);
    vec_t v;
    logic [63:0] r64;
    int k;
    r64 = {$urandom, $urandom};
    v.name = name;
    v.e = E'($urandom_range(1, 11'h7FD));
    if ($urandom_range(0, 9) == 0) v.m = 57'd1 << 56;
    else v.m = {2'b01, r64[54:0]};
    k = $urandom_range(0, 7);
    v.z = (k == 0);
    v.f = (k == 1);
    v.n = (k == 2);
    v.s = (k < 3) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
    v.result = '0; v.inv = 1'b0; v.dbz = 1'b0;
    return v;
  endfunction

  vec_t tv[13];
  logic [WM-1:0] one_m, two_m, all_m;

  initial begin
    vec_t v;
    exp_t x;
    one_m = 57'd1 << 55;
    two_m = 57'd1 << 56;
    all_m = (57'd1 << 56) - 57'd1;
    tv[0]  = mk("two_3fe",    11'h3FE, two_m, 0, 0, 0, 0, 64'h3FF0000000000000, 0, 0);
    tv[1]  = mk("two_3fd",    11'h3FD, two_m, 0, 0, 0, 0, 64'h3FE0000000000000, 0, 0);
    tv[2]  = mk("tie_odd",    11'h3FF, one_m + 57'd12, 0, 0, 0, 0, 64'h3FF0000000000002, 0, 0);
    tv[3]  = mk("tie_even",   11'h3FF, one_m + 57'd4, 0, 0, 0, 0, 64'h3FF0000000000000, 0, 0);
    tv[4]  = mk("carry",      11'h3FF, all_m, 0, 0, 0, 0, 64'h4000000000000000, 0, 0);
    tv[5]  = mk("below_half", 11'h3FF, one_m + 57'd43, 0, 0, 0, 0, 64'h3FF0000000000005, 0, 0);
    tv[6]  = mk("above_half", 11'h3FF, one_m + 57'd37, 0, 0, 0, 0, 64'h3FF0000000000005, 0, 0);
    tv[7]  = mk("pos_zero",   11'h000, '0, 0, 1, 0, 0, 64'h7FF0000000000000, 0, 1);
    tv[8]  = mk("neg_zero",   11'h000, '0, 1, 1, 0, 0, 64'hFFF0000000000000, 0, 1);
    tv[9]  = mk("pos_inf",    11'h7FF, '0, 0, 0, 1, 0, 64'h0000000000000000, 0, 0);
    tv[10] = mk("neg_inf",    11'h7FF, '0, 1, 0, 1, 0, 64'h7FF8000000000000, 1, 0);
    tv[11] = mk("nan",        11'h7FF, one_m, 1, 0, 0, 1, 64'h7FF8000000000000, 0, 0);
    tv[12] = mk("neg_finite", 11'h3FF, one_m, 1, 0, 0, 0, 64'h7FF8000000000000, 1, 0);

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_exp_invsqrt_minus1 = '0; i_mant = '0; i_sign = 1'b0;
    i_is_zero = 1'b0; i_is_inf = 1'b0; i_is_nan = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_o_valid", 64'(o_valid), 64'd0);
    check("reset_o_result", o_result, 64'd0);
    check("reset_o_invalid", 64'(o_invalid), 64'd0);
    check("reset_o_dbz", 64'(o_divide_by_zero), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_after_reset", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      x.result = tv[i].result; x.inv = tv[i].inv; x.dbz = tv[i].dbz; x.name = tv[i].name;
      send(tv[i], x);
      if (i % 3 == 2) repeat (2) @(posedge i_clk);
      #0;
    end
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      v = rand_vec($sformatf("rand%0d", i));
      send(v, model(v));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge i_clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge i_clk);
    #2;
    i_ready = 1'b1;
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) begin
          v = rand_vec($sformatf("bp%0d", i));
          v.z = 1'b0; v.f = 1'b0; v.n = 1'b0; v.s = 1'b0;
          send(v, model(v));
        end
      end
      begin
        repeat (4) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("full_stall_o_ready", 64'(o_ready), 64'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    i_ready = 1'b0;
    v = rand_vec("rst0"); v.z = 1'b0; v.f = 1'b0; v.n = 1'b0; v.s = 1'b0;
    send(v, model(v));
    v = rand_vec("rst1"); v.z = 1'b0; v.f = 1'b0; v.n = 1'b0; v.s = 1'b0;
    send(v, model(v));
    @(negedge i_clk);
    check("inflight_o_valid", 64'(o_valid), 64'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_reset_o_valid", 64'(o_valid), 64'd0);
    sb.delete();
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(negedge i_clk);
    check("ready_after_midrun_reset", 64'(o_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check("no_stale_output", 64'(o_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ipsxe_floating_point_invsqrt_pack_v1_0.md
Name: ipsxe_floating_point_invsqrt_pack_v1_0

Overview:
- Final output stage of the floating-point inverse square-root datapath.
- Consumes two upstream results and produces the IEEE-754 result word plus exception flags:
  - the biased result exponent already reduced by 1 (exp_invsqrt_minus1 stage);
  - the fixed-point 2x mantissa from the iteration stage.
- Performs round-to-nearest-even, carry/renormalisation, special-value override and packing.
- 2-stage pipeline with valid/ready flow control.

Parameters:
- EXPONENT_SIZE, 11, exponent field width.
- MANTISSA_SIZE, 52, stored fraction width.
- GUARD_BITS, 3, extra fraction bits below the LSB for rounding (>=2).

Ports:
- i_clk  input  1  clock; all registers rise-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  block can accept this cycle.
- i_exp_invsqrt_minus1  input  EXPONENT_SIZE  biased exponent, already minus 1.
- i_mant  input  MANTISSA_SIZE+GUARD_BITS+2  unsigned fixed point, 2 integer bits, value in [1.0, 2.0].
- i_sign  input  1  operand sign.
- i_is_zero / i_is_inf / i_is_nan  input  1 each  operand class from unpack stage; mutually exclusive.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts.
- o_result  output  EXPONENT_SIZE+MANTISSA_SIZE+1  packed IEEE word.
- o_invalid  output  1  invalid-operation flag.
- o_divide_by_zero  output  1  divide-by-zero flag.

Behaviour:
- Reset: i_clk single clock; i_rst_n asynchronous assert, active-low.
  - All pipeline valids clear; o_valid=0, o_result=0, o_invalid=0, o_divide_by_zero=0.
  - Data registers may also clear to 0.
  - o_ready=1 from the first cycle after deassertion.
- Handshake: transfer in when i_valid&o_ready; transfer out when o_valid&i_ready.
  - Stage k loads when its valid is 0, or when the next stage/downstream consumes this cycle.
  - o_ready = ~v1 | (~v2 | i_ready).
  - Latency 2 cycles; throughput 1/cycle with i_ready held high.
  - Full stall with both stages holding: o_ready=0; held data and o_result stable, no loss or duplication.
  - o_valid must not drop without a transfer.
- Stage 1 (round):
  - lsb = i_mant[GUARD_BITS], rnd = i_mant[GUARD_BITS-1], sticky = OR of i_mant[GUARD_BITS-2:0].
  - Increment = rnd & (sticky | lsb).
  - Rounded value = i_mant[top:GUARD_BITS] + increment, width MANTISSA_SIZE+2.
  - Registers: rounded value, exponent, sign, class bits.
- Stage 2 (normalise/pack):
  - If rounded value bit[MANTISSA_SIZE+1]=1 (value 2.0, from exact input 2.0 or a round carry): exp_out = exp+1, frac = 0.
  - Otherwise: exp_out = exp, frac = rounded[MANTISSA_SIZE-1:0].
  - Exponent arithmetic is modulo 2^EXPONENT_SIZE. Upstream guarantees normalised, non-subnormal operands, so exp_out never reaches all-ones or zero.
- Special-case priority, applied in stage 2:
  1. nan: canonical qNaN, sign 0, exp all-ones, frac MSB 1, rest 0; no flag.
  2. zero: sign = i_sign, exp all-ones, frac 0 (±inf); o_divide_by_zero=1.
  3. inf & ~sign: +0, all zero.
  4. inf & sign, or finite & sign: canonical qNaN; o_invalid=1.
  5. else finite positive: sign 0, exp_out, frac.
- Flags are per-result, valid only while o_valid=1; they are zero for normal results.
- Reset asserted mid-operation: in-flight results are discarded; no output appears after reset release without new input.

Decomposition:
- Shared package (ipsxe_floating_point_pkg) holds:
  - derived width constants: W_MANT_IN = MANTISSA_SIZE+GUARD_BITS+2, W_RESULT = EXPONENT_SIZE+MANTISSA_SIZE+1;
  - qNaN/inf/zero pattern constants;
  - class-bit encoding.
- One natural sub-module: ipsxe_floating_point_round_rne_v1_0, combinational RNE incrementer (value, guard bits -> rounded value), reusable by other ops.

Test Plan:
- Double, i_exp_invsqrt_minus1=11'h3FE, i_mant=2.0 (top bit 1, rest 0) -> after 2 cycles o_result=64'h3FF0000000000000, flags 0.
- i_exp_invsqrt_minus1=11'h3FD, i_mant=2.0 -> 64'h3FE0000000000000.
- RNE cases, exp 11'h3FF:
  - i_mant = 1.0 + 1 LSB + exactly half LSB -> frac rounds up to 2 LSB (tie, odd lsb);
  - i_mant = 1.0 + half LSB -> frac 0 (tie, even);
  - all fraction and guard bits ones -> result exp 11'h400, frac 0 (carry).
- Specials:
  - +0 -> 64'h7FF0000000000000, o_divide_by_zero=1;
  - -0 -> 64'hFFF0000000000000, o_divide_by_zero=1;
  - +inf -> 0;
  - -inf -> 64'h7FF8000000000000, o_invalid=1;
  - NaN -> 64'h7FF8000000000000, no flags;
  - negative finite -> qNaN, o_invalid=1.
- Backpressure: stream 8 back-to-back inputs, i_ready low for 3 cycles mid-stream -> o_ready=0 once both stages are full, all 8 results in order, none dropped or duplicated, o_result stable while stalled.
- Drive i_rst_n low with 2 results in flight -> o_valid=0 immediately (asynchronous), o_ready=1 after release, no stale result appears.
